// File: rtl/delay_circuit_pkg.sv
// delay_circuit_pkg: shared latency defaults, run-counter type and saturating increment helper
package delay_circuit_pkg;
  localparam int OR_LAT_DEF    = 3;
  localparam int NOT_LAT_DEF   = 1;
  localparam int AND_LAT_DEF   = 2;
  localparam int MIN_PULSE_DEF = 3;
  localparam int CNT_W         = 4;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t sat_inc(input cnt_t c, input cnt_t lim);
    return (c >= lim) ? lim : c + cnt_t'(1);
  endfunction
endpackage

// File: rtl/delay_circuit_pipe_lat_pipe.sv
// lat_pipe: LAT-cycle transport delay of a WIDTH-bit bus; ports clk, rst (sync active-high), d in, q out
module lat_pipe #(
  parameter int WIDTH = 1,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) s[i] <= '0;
    end else begin
      s[0] <= d;
      for (int i = 1; i < LAT; i++) s[i] <= s[i-1];
    end
  end
  assign q = s[LAT-1];
endmodule

// File: rtl/delay_circuit_pipe.sv
// delay_circuit_pipe: x = delayed (A|B)&~C, y = delayed ~C, sticky short-pulse glitch flag on x; ports clk, rst, A, B, C, glitch_clr in, x, y, glitch out; glitch logic present only with DELAY_CIRCUIT_GLITCH_DET_EN
module delay_circuit_pipe
  import delay_circuit_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int OR_LAT    = OR_LAT_DEF,
  parameter int NOT_LAT   = NOT_LAT_DEF,
  parameter int AND_LAT   = AND_LAT_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             glitch_clr,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] glitch
);
  logic [WIDTH-1:0] e;
  lat_pipe #(.WIDTH(WIDTH), .LAT(OR_LAT))  u_or  (.clk(clk), .rst(rst), .d(A | B), .q(e));
  lat_pipe #(.WIDTH(WIDTH), .LAT(NOT_LAT)) u_not (.clk(clk), .rst(rst), .d(~C),    .q(y));
  lat_pipe #(.WIDTH(WIDTH), .LAT(AND_LAT)) u_and (.clk(clk), .rst(rst), .d(e & y), .q(x));
`ifdef DELAY_CIRCUIT_GLITCH_DET_EN
  localparam cnt_t MIN_C = cnt_t'(MIN_PULSE);
  cnt_t             run [WIDTH];
  logic [WIDTH-1:0] short_end;
  // run holds the length of the x-high run ending last cycle, so a nonzero
  // run with x now low marks a falling edge
  always_comb begin
    for (int i = 0; i < WIDTH; i++) short_end[i] = !x[i] && (run[i] != '0) && (run[i] < MIN_C);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) run[i] <= '0;
      glitch <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) run[i] <= x[i] ? sat_inc(run[i], MIN_C) : '0;
      glitch <= short_end | (glitch & ~{WIDTH{glitch_clr}});
    end
  end
`else
  logic unused_clr;
  assign unused_clr = glitch_clr;
  assign glitch = '0;
`endif
endmodule

// File: doc/delay_circuit_pipe.md
DELAY_CIRCUIT_PIPE -- requirements
Module: delay_circuit_pipe

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bit-lanes; every signal port below is WIDTH bits wide unless stated.
REQ-002 Parameter OR_LAT, default 3: cycle latency of OR stage (e = A|B); legal range 1..16.
REQ-003 Parameter NOT_LAT, default 1: cycle latency of NOT stage (y = ~C); legal range 1..16.
REQ-004 Parameter AND_LAT, default 2: cycle latency of AND stage (x = e&y); legal range 1..16.
REQ-005 Parameter MIN_PULSE, default 3: shortest legal x high-pulse in cycles; legal range 2..15.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 A  input  WIDTH  OR operand 1.
REQ-009 B  input  WIDTH  OR operand 2.
REQ-010 C  input  WIDTH  NOT operand.
REQ-011 glitch_clr  input  1  clears sticky glitch flags.
REQ-012 x  output  WIDTH  delayed (A|B)&~C.
REQ-013 y  output  WIDTH  delayed ~C.
REQ-014 glitch  output  WIDTH  sticky per-lane short-pulse flag.

Function
REQ-015 Lanes SHALL be fully independent; bit i of each output depends only on bit i of A, B, C.
REQ-016 Notation: s[n] = value of s during cycle n; a stage of latency L SHALL give q[n] = d[n-L] (pure transport, no pulse filtering).
REQ-017 e[n] SHALL equal (A|B)[n-OR_LAT]; e is internal, not a port.
REQ-018 y[n] SHALL equal ~C[n-NOT_LAT].
REQ-019 x[n] SHALL equal e[n-AND_LAT] & y[n-AND_LAT]; x latency is AND_LAT after the internal e/y values, so unequal OR_LAT/NOT_LAT SHALL produce transport hazards on x.
REQ-020 Per lane, a high-run counter SHALL count consecutive cycles of x=1, saturating at MIN_PULSE, and zero on any cycle with x=0.
REQ-021 When x[n]=0, x[n-1]=1 and the run length < MIN_PULSE, glitch SHALL be 1 from cycle n+1 and remain 1 until cleared.
REQ-022 glitch_clr=1 SHALL clear all glitch bits in the next cycle; if a new short pulse ends in the same cycle as glitch_clr, set SHALL win.
REQ-023 A run still in progress or one reaching MIN_PULSE SHALL never set glitch.

Reset
REQ-024 rst=1 at a rising edge SHALL zero all pipeline stages, counters and flags: x=0, y=0, glitch=0 in the following cycle.
REQ-025 Reset mid-operation SHALL flush in-flight values; after release y SHALL show ~C from NOT_LAT cycles later; the 0->1 y transition caused by the flush SHALL be treated as ordinary data.
REQ-026 Counters SHALL treat cycle after reset as x=0 history (no pulse straddles reset).

Configuration
REQ-027 Macro DELAY_CIRCUIT_GLITCH_DET_EN: defined -> REQ-020..023 logic present; undefined -> counters removed, glitch tied to 0, glitch_clr ignored, ports retained.

Structure
REQ-028 Package delay_circuit_pkg SHALL hold default latency constants (3,1,2), MIN_PULSE default, and counter width constant (4 bits).
REQ-029 One sub-module lat_pipe (parameters WIDTH, LAT; sync active-high reset to 0) SHALL implement each stage; instantiated three times.

Verification (defaults, WIDTH=1, macro defined)
REQ-030 Reset, A=B=C=0 held from cycle 0 -> y=1 from cycle 1, x=0 throughout, glitch=0.
REQ-031 Steady A=0,B=0,C=1; cycle 10 set A=1,C=0 -> y=1 from 11, x=1 from 15, glitch stays 0.
REQ-032 Steady A=1,C=1 (x=0); cycle 10 set A=0,C=0 -> y=1 from 11, x=1 in cycles 13-14, x=0 from 15, glitch=1 from 16.
REQ-033 After REQ-032, glitch_clr=1 in cycle 20 -> glitch=0 from 21; repeat with rst in cycle 12 -> x stays 0, glitch stays 0.
REQ-034 WIDTH=4, OR_LAT=NOT_LAT=2: lanes driven with different A/B/C patterns, including the REQ-032 transition -> per-lane x matches REQ-019, no hazard, glitch=0 on all lanes.
REQ-035 Macro undefined, REQ-032 stimulus -> identical x/y, glitch=0 always.
